// File: rtl/i2s_tx_serializer.sv
// I2S playback transmitter: stereo pairs from a small FIFO shifted out MSB-first,
// one BCLK after each LRCLK edge. BCLK/LRCLK are oversampled in the clk domain.
//
// state     | meaning
// IDLE      | disabled, output held 0, load arms cleared
// WAIT_LEFT | enabled, waiting for an LRCLK 1->0 boundary so output starts on a left slot
// RUN       | shifting samples out on each BCLK fall
module i2s_tx_serializer #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  input  logic                          bclk_in,
  input  logic                          lrclk_in,
  output logic                          sdata_out,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_LEFT, RUN} state_t;

  state_t state, state_nxt;

  logic bclk_m, bclk_s, bclk_d;
  logic lrclk_m, lrclk_s, lr_prev;
  logic bclk_rise, bclk_fall, left_edge, right_edge;

  logic load_left, load_right;
  logic run_fall, do_left, do_right;
  logic [DATA_W-1:0] shift_reg, shift_nxt, right_hold;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [2*DATA_W-1:0] rd_data;
  logic                fifo_empty, push, pop;

  // Synchronisers and BCLK edge detect; LRCLK is only looked at on BCLK rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_m  <= 1'b0;
      bclk_s  <= 1'b0;
      bclk_d  <= 1'b0;
      lrclk_m <= 1'b0;
      lrclk_s <= 1'b0;
      lr_prev <= 1'b0;
    end else begin
      bclk_m  <= bclk_in;
      bclk_s  <= bclk_m;
      bclk_d  <= bclk_s;
      lrclk_m <= lrclk_in;
      lrclk_s <= lrclk_m;
      if (bclk_rise) lr_prev <= lrclk_s;
    end
  end

  assign bclk_rise  = bclk_s & ~bclk_d;
  assign bclk_fall  = ~bclk_s & bclk_d;
  assign left_edge  = bclk_rise & lr_prev & ~lrclk_s;
  assign right_edge = bclk_rise & ~lr_prev & lrclk_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_fall  = 1'b0;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_LEFT;
      WAIT_LEFT: if (left_edge) state_nxt = RUN;
      RUN:       run_fall = bclk_fall & enable;
      default:   state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Left load has priority; both arms can never be pending on a single fall in a sane frame.
  assign do_left  = run_fall & load_left;
  assign do_right = run_fall & ~load_left & load_right;

  assign fifo_empty = (fifo_level == '0);
  assign s_ready    = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push       = s_valid & s_ready;
  assign pop        = do_left & ~fifo_empty;
  assign rd_data    = mem[rd_ptr];

  always_comb begin
    shift_nxt = {shift_reg[DATA_W-2:0], 1'b0};
    if (do_left)       shift_nxt = fifo_empty ? '0 : rd_data[2*DATA_W-1:DATA_W];
    else if (do_right) shift_nxt = right_hold;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {s_left, s_right};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_left  <= 1'b0;
      load_right <= 1'b0;
      shift_reg  <= '0;
      right_hold <= '0;
      sdata_out  <= 1'b0;
    end else if (!enable || state == IDLE) begin
      load_left  <= 1'b0;
      load_right <= 1'b0;
      shift_reg  <= '0;
      sdata_out  <= 1'b0;
    end else if (state == WAIT_LEFT) begin
      load_left  <= left_edge;
      load_right <= 1'b0;
      sdata_out  <= 1'b0;
    end else begin
      if (left_edge)    load_left <= 1'b1;
      else if (do_left) load_left <= 1'b0;
      if (right_edge)    load_right <= 1'b1;
      else if (do_right) load_right <= 1'b0;
      // An empty FIFO at a left load sends a silent frame for both channels.
      if (do_left) right_hold <= fifo_empty ? '0 : rd_data[DATA_W-1:0];
      if (run_fall) begin
        shift_reg <= shift_nxt;
        sdata_out <= shift_nxt[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 underrun <= 1'b0;
    else if (do_left & fifo_empty) underrun <= 1'b1;
    else if (underrun_clr)        underrun <= 1'b0;
  end

endmodule
